// File: rtl/fb_pkg.sv
// Shared constants and FSM encoding for the double-buffered 1bpp framebuffer.
package fb_pkg;

  localparam int HOR_DEFAULT = 640;
  localparam int VER_DEFAULT = 480;
  localparam int PIXEL_COUNT = HOR_DEFAULT * VER_DEFAULT;
  localparam int ADDR_WIDTH  = $clog2(PIXEL_COUNT);

  typedef enum logic [1:0] {
    DRAW      = 2'd0,
    WAIT_SWAP = 2'd1,
    CLEAR     = 2'd2
  } state_t;

endpackage

// File: rtl/fb_bank.sv
// One 1-bit simple dual-port pixel bank: one write port, one registered read port.
module fb_bank #(
  parameter int DEPTH = 307200,
  parameter int AW    = 19
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic          wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic          rdata
);

  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered 1bpp framebuffer: scanout reads the front bank, the plotter writes the back bank.
// Define FRAME_BUFFER_CLEAR_EN to auto-clear the new back bank after every exchange.
module frame_buffer
  import fb_pkg::*;
#(
  parameter int  HOR_ACTIVE_PIXELS = 640,
  parameter int  VER_ACTIVE_PIXELS = 480,
  localparam int NUM_PIXELS        = HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS,
  localparam int ADDR_WIDTH        = $clog2(NUM_PIXELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_data,
  input  logic                  swap,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic                  write_data,
  input  logic                  write_en,
  input  logic                  frame_done,
  output logic                  ready,
  output logic                  front_bank
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam state_t AFTER_SWAP = CLEAR;
`else
  localparam state_t AFTER_SWAP = DRAW;
`endif

  state_t                  state_reg, state_next;
  logic                    front_reg, front_next;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    wr_data;
  logic                    rd_en;
  logic                    rd_valid_reg;
  logic                    rd_bank_reg;
  logic [1:0]              bank_q;

`ifdef FRAME_BUFFER_CLEAR_EN
  logic [ADDR_WIDTH-1:0]   clear_addr_reg, clear_addr_next;
`endif

  always_comb begin
    state_next = state_reg;
    front_next = front_reg;
    wr_en      = 1'b0;
    wr_addr    = write_addr;
    wr_data    = write_data;
    ready      = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
    clear_addr_next = clear_addr_reg;
`endif
    case (state_reg)
      DRAW: begin
        ready = 1'b1;
        wr_en = write_en && (write_addr <= LAST_ADDR);
        if (frame_done) begin
          // A swap arriving with frame_done is taken at once rather than waiting a frame.
          if (swap) begin
            front_next = ~front_reg;
            state_next = AFTER_SWAP;
          end else begin
            state_next = WAIT_SWAP;
          end
        end
      end
      WAIT_SWAP: begin
        if (swap) begin
          front_next = ~front_reg;
          state_next = AFTER_SWAP;
        end
      end
`ifdef FRAME_BUFFER_CLEAR_EN
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clear_addr_reg;
        wr_data = 1'b0;
        if (clear_addr_reg == LAST_ADDR) begin
          clear_addr_next = '0;
          state_next      = DRAW;
        end else begin
          clear_addr_next = clear_addr_reg + 1'b1;
        end
      end
`endif
      default: begin
        state_next = DRAW;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= AFTER_SWAP;
      front_reg <= 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
      clear_addr_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      front_reg <= front_next;
`ifdef FRAME_BUFFER_CLEAR_EN
      clear_addr_reg <= clear_addr_next;
`endif
    end
  end

  // Blanking addresses skip the RAM; the bank is latched with the address so a swap cannot disturb it.
  assign rd_en = (read_addr <= LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_reg <= 1'b0;
      rd_bank_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en;
      rd_bank_reg  <= front_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      fb_bank #(
        .DEPTH(NUM_PIXELS),
        .AW   (ADDR_WIDTH)
      ) u_bank (
        .clk  (clk),
        .we   (wr_en && (front_reg != 1'(gi))),
        .waddr(wr_addr),
        .wdata(wr_data),
        .re   (rd_en && (front_reg == 1'(gi))),
        .raddr(read_addr),
        .rdata(bank_q[gi])
      );
    end
  endgenerate

  assign read_data  = rd_valid_reg & bank_q[rd_bank_reg];
  assign front_bank = front_reg;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer; with FRAME_BUFFER_CLEAR_EN it uses a reduced geometry to keep clears short.
module tb_frame_buffer;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam int H    = 64;
  localparam int V    = 48;
  localparam int OOR2 = 4000;
  localparam logic RST_READY = 1'b0;
`else
  localparam int H    = 640;
  localparam int V    = 480;
  localparam int OOR2 = 400000;
  localparam logic RST_READY = 1'b1;
`endif
  localparam int PC = H * V;
  localparam int AW = $clog2(PC);

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] read_addr;
  logic          read_data;
  logic          swap;
  logic [AW-1:0] write_addr;
  logic          write_data;
  logic          write_en;
  logic          frame_done;
  logic          ready;
  logic          front_bank;

  frame_buffer #(
    .HOR_ACTIVE_PIXELS(H),
    .VER_ACTIVE_PIXELS(V)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .read_addr (read_addr),
    .read_data (read_data),
    .swap      (swap),
    .write_addr(write_addr),
    .write_data(write_data),
    .write_en  (write_en),
    .frame_done(frame_done),
    .ready     (ready),
    .front_bank(front_bank)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   addr;
    logic exp;
  } rd_vec_t;

  rd_vec_t rd_tbl [9];
  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
      $display("ok   %s value=%0d", name, act);
    end else begin
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_px(input int addr, input logic data);
    write_addr = AW'(addr);
    write_data = data;
    write_en   = 1'b1;
    tick();
    write_en   = 1'b0;
  endtask

  task automatic read_px(input int addr, output logic data);
    read_addr = AW'(addr);
    tick();
    data = read_data;
  endtask

  task automatic pulse(input logic fd, input logic sw);
    frame_done = fd;
    swap       = sw;
    tick();
    frame_done = 1'b0;
    swap       = 1'b0;
  endtask

  // Counts cycles from the first CLEAR cycle until ready rises.
  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (!ready && n < PC + 10) begin
      tick();
      n++;
    end
    check(name, n, PC);
  endtask

  // Call right after the tick on which a swap was accepted.
  task automatic after_swap(input string name);
`ifdef FRAME_BUFFER_CLEAR_EN
    check({name, "_ready_low"}, ready, 0);
    wait_clear({name, "_clear_len"});
`else
    check({name, "_ready"}, ready, 1);
`endif
  endtask

  initial begin
    logic d;
    int   ones;

    rd_tbl[0] = '{1000, 1'b1};
    rd_tbl[1] = '{999, 1'b0};
    rd_tbl[2] = '{1001, 1'b0};
    rd_tbl[3] = '{0, 1'b0};
    rd_tbl[4] = '{PC - 1, 1'b1};
    rd_tbl[5] = '{5, 1'b1};
    rd_tbl[6] = '{6, 1'b0};
    rd_tbl[7] = '{PC, 1'b0};
    rd_tbl[8] = '{OOR2, 1'b0};

    rst = 1'b1; read_addr = '0; swap = 1'b0; write_addr = '0;
    write_data = 1'b0; write_en = 1'b0; frame_done = 1'b0;
    repeat (3) tick();
    check("rst_read_data", read_data, 0);
    check("rst_front_bank", front_bank, 0);
    check("rst_ready", ready, RST_READY);
    rst = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
    wait_clear("rst_clear_len");
`endif

    // Draw into bank 1, including an out-of-range write and a write coincident with frame_done.
    write_px(999, 1'b0);
    write_px(1000, 1'b1);
    write_px(1001, 1'b0);
    write_px(0, 1'b0);
    write_px(PC - 1, 1'b1);
    write_px(6, 1'b0);
    write_px(PC, 1'b1);
    write_addr = AW'(5); write_data = 1'b1; write_en = 1'b1;
    pulse(1'b1, 1'b0);
    write_en = 1'b0;
    check("wait_swap_ready", ready, 0);
    check("wait_swap_front", front_bank, 0);
    write_px(6, 1'b1);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("swap1_front", front_bank, 1);
    after_swap("swap1");

    for (int i = 0; i < 9; i++) begin
      read_px(rd_tbl[i].addr, d);
      check($sformatf("read_tbl[%0d]_addr%0d", i, rd_tbl[i].addr), d, rd_tbl[i].exp);
    end

    // Swaps without frame_done are ignored while drawing.
    read_addr = AW'(1000);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1);
      check($sformatf("ignored_swap%0d_front", i), front_bank, 1);
      check($sformatf("ignored_swap%0d_data", i), read_data, 1);
    end

    // frame_done and swap together: exchange on that same edge.
    write_px(1000, 1'b0);
    write_px(2000, 1'b1);
    pulse(1'b1, 1'b1);
    check("simul_front", front_bank, 0);
    after_swap("simul");
    read_px(2000, d);
    check("simul_read2000", d, 1);

    // A read issued on the swap edge still returns the old front bank.
    write_px(1000, 1'b1);
    pulse(1'b1, 1'b0);
    read_addr = AW'(1000);
    pulse(1'b0, 1'b1);
    check("inflight_data", read_data, 0);
    check("inflight_front", front_bank, 1);
    after_swap("inflight");
    read_px(1000, d);
    check("new_front_read1000", d, 1);

    // Bank 0 becomes front again: stale pixel survives without clear, is erased with it.
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    check("swap4_front", front_bank, 0);
    after_swap("swap4");
    read_px(2000, d);
`ifdef FRAME_BUFFER_CLEAR_EN
    check("cleared_read2000", d, 0);
    ones = 0;
    for (int a = 0; a < PC; a++) begin
      read_px(a, d);
      if (d !== 1'b0) ones++;
    end
    check("cleared_bank_nonzero", ones, 0);
`else
    check("stale_read2000", d, 1);
`endif

    // Reset in the middle of operation (mid-clear when clearing is built in).
    pulse(1'b1, 1'b1);
    check("pre_rst_front", front_bank, 1);
`ifdef FRAME_BUFFER_CLEAR_EN
    repeat (PC / 2) tick();
    check("mid_clear_ready", ready, 0);
`endif
    rst = 1'b1;
    repeat (3) tick();
    check("mid_rst_front", front_bank, 0);
    check("mid_rst_ready", ready, RST_READY);
    rst = 1'b0;
`ifdef FRAME_BUFFER_CLEAR_EN
    wait_clear("mid_rst_clear_len");
`else
    read_px(2000, d);
    check("post_rst_front_kept", d, 1);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/frame_buffer.md
Name: frame_buffer

Overview:
- Double-buffered 1-bit-per-pixel framebuffer directly upstream of the VGA scanout stage.
- Serves that stage's read_addr/read_data port from the front bank.
- Accepts pixel writes from the plotter into the back bank.
- Exchanges banks on the scanout's end-of-frame swap pulse, only once the plotter has declared its frame complete.
- Optionally auto-clears the new back bank after each exchange.

Parameters:
- HOR_ACTIVE_PIXELS, 640, visible pixels per line.
- VER_ACTIVE_PIXELS, 480, visible lines per frame.
- ADDR_WIDTH, $clog2(HOR_ACTIVE_PIXELS*VER_ACTIVE_PIXELS) = 19, pixel address width. Derived localparam, not overridable.

Ports:
- clk  input  1  pixel clock, same domain as scanout.
- rst  input  1  synchronous, active-high reset.
- read_addr  input  ADDR_WIDTH  scanout pixel address, y*HOR_ACTIVE_PIXELS+x.
- read_data  output  1  front-bank pixel at read_addr.
- swap  input  1  one-cycle end-of-frame pulse from scanout.
- write_addr  input  ADDR_WIDTH  plotter pixel address.
- write_data  input  1  pixel value.
- write_en  input  1  write strobe, back bank.
- frame_done  input  1  one-cycle pulse: plotter finished current back-bank frame.
- ready  output  1  back bank accepting writes.
- front_bank  output  1  index of bank currently scanned out.

Behaviour:
- Reset values:
  - front_bank=0, ready=0, read_data=0.
  - State CLEAR, clear_addr=0 (FRAME_BUFFER_CLEAR_EN defined); otherwise state DRAW, ready=1.
- Read path:
  - read_data registered, latency exactly 1 cycle from read_addr.
  - read_addr >= PIXEL_COUNT (307200; blanking region) returns 0 on the next cycle, no bank access.
  - Read bank is sampled with the address; a swap does not corrupt the in-flight read.
- States:
  - DRAW: ready=1. write_en with write_addr < PIXEL_COUNT writes write_data into bank ~front_bank. Out-of-range write addresses are ignored. frame_done -> WAIT_SWAP.
  - WAIT_SWAP: ready=0, writes ignored. On swap: front_bank toggles, then -> CLEAR (or DRAW when the clear is compiled out).
  - CLEAR: ready=0, writes ignored. Writes 0 to back-bank address clear_addr and increments it. At clear_addr == PIXEL_COUNT-1: write it, reset clear_addr to 0, -> DRAW. Duration exactly PIXEL_COUNT cycles (under one 420000-cycle frame).
- Simultaneous events:
  - frame_done and swap in the same DRAW cycle: swap taken immediately, front_bank toggles that cycle.
  - write_en with frame_done in DRAW: the write is committed.
  - swap in DRAW or CLEAR: ignored, front_bank unchanged; the frame repeats on screen.
  - frame_done outside DRAW: ignored.
- front_bank changes only on the clock edge after a swap is accepted, so a new frame starts cleanly at scan address 0.
- rst mid-operation (any state, including mid-CLEAR): state restarts as at reset, front_bank=0. Front-bank contents are not cleared by reset.

Optional Feature:
- Macro FRAME_BUFFER_CLEAR_EN.
- Defined: CLEAR state exists, behaving as above, including after reset.
- Undefined:
  - No CLEAR state and no clear_addr counter.
  - After reset and after every accepted swap the block enters DRAW with ready=1 on the next cycle.
  - The back bank keeps stale content; the plotter is responsible for erasing.

Decomposition:
- Package fb_pkg:
  - state encoding (DRAW, WAIT_SWAP, CLEAR);
  - PIXEL_COUNT and ADDR_WIDTH constants derived from 640x480 defaults.
- Sub-module fb_bank, instantiated twice:
  - single 1-bit simple dual-port RAM, PIXEL_COUNT deep;
  - one write port, one synchronous read port, 1-cycle latency;
  - no reset on contents;
  - inferable as block RAM.
- Top level holds the FSM, bank select, clear counter and muxes.

Test Plan:
- Reset with clear enabled, hold rst 3 cycles:
  - ready=0 for 307200 cycles after rst drops, then ready=1;
  - front_bank=0;
  - read of back-bank address 0..307199 after a forced swap returns all 0.
- DRAW write 1 at addr 1000, frame_done, then swap:
  - front_bank=1 one cycle after swap;
  - read_addr=1000 gives read_data=1 one cycle later;
  - addr 999 and 1001 give 0.
- Swap with no frame_done:
  - front_bank stays 0;
  - read_addr=1000 data unchanged across 3 consecutive swap pulses.
- Out-of-range access:
  - read_addr=307200 and 400000 return 0;
  - write_en at write_addr=307200 leaves bank contents unchanged (check addr 0 and 307199).
- frame_done and swap asserted in the same cycle during DRAW: front_bank toggles on that edge; the state is CLEAR on the next cycle.
- rst asserted at clear_addr=150000:
  - front_bank returns to 0;
  - clear restarts, ready rises exactly 307200 cycles after rst deasserts.
- Clear compiled out: ready=1 one cycle after an accepted swap, and a previously written back-bank pixel still reads 1 after the next swap.
